m_port_bank: RTL and testbench

//  Parametrised bank of PicoBlaze output registers. Generalises the single-port latch to:
//  - NCH channels of WIDTH bits each, mapped to consecutive port_id addresses.
//  - Atomic multi-byte update and per-channel update strobe.
//  - Byte readback via in_port.
//  - Optional auto-clearing pulse mode.

---
 rtl/m_port_bank.sv | 130 +++++++++++++
 tb/tb_m_port_bank.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/m_port_bank.sv
// Bank of NCH PicoBlaze output registers on the KCPSM port bus: shadowed multi-byte
// writes committed atomically on the top byte, registered byte readback, optional pulse mode.

module m_port_bank_ch #(
  parameter int              WIDTH     = 16,
  parameter int              NB        = 2,
  parameter bit              PULSE     = 1'b0,
  parameter int              PULSE_LEN = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [7:0]       bsel_i,
  input  logic [7:0]       data_i,
  output logic [WIDTH-1:0] val_o,
  output logic             upd_o
);
  logic [NB*8-1:0]  shadow_q, shadow_d, word;
  logic [WIDTH-1:0] val_q, val_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             upd_q, upd_d, commit;

  always_comb begin
    commit = wr_i && (bsel_i == 8'(NB-1));
    // Commit word: incoming top byte over the retained lower shadow bytes.
    word = shadow_q;
    word[(NB-1)*8 +: 8] = data_i;
    shadow_d = shadow_q;
    for (int k = 0; k < NB-1; k++)
      if (wr_i && bsel_i == 8'(k)) shadow_d[k*8 +: 8] = data_i;
    val_d = val_q;
    cnt_d = cnt_q;
    upd_d = 1'b0;
    if (commit) begin
      val_d = WIDTH'(word);
      upd_d = 1'b1;
      cnt_d = PULSE ? 16'(PULSE_LEN) : 16'd0;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
      if (cnt_q == 16'd1) val_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      val_q    <= RESET_VAL;
      cnt_q    <= '0;
      upd_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      val_q    <= val_d;
      cnt_q    <= cnt_d;
      upd_q    <= upd_d;
    end
  end

  assign val_o = val_q;
  assign upd_o = upd_q;
endmodule

module m_port_bank #(
  parameter int               NCH        = 4,
  parameter int               WIDTH      = 16,
  parameter logic [7:0]       BASE       = 8'h00,
  parameter logic [NCH-1:0]   PULSE_MASK = '0,
  parameter int               PULSE_LEN  = 16,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           port_id,
  input  logic [7:0]           out_port,
  input  logic                 write_strobe,
  output logic [7:0]           in_port,
  output logic                 hit,
  output logic [NCH*WIDTH-1:0] out,
  output logic [NCH-1:0]       upd
);
  localparam int NB = (WIDTH + 7) / 8;

  logic [15:0]                 off;
  logic                        in_range;
  logic [NCH-1:0][WIDTH-1:0]   val;
  logic [NCH-1:0][NB*8-1:0]    vext;
  logic [7:0]                  in_port_q, in_port_d;
  logic                        hit_q;

  // 16-bit offset: port_id below BASE wraps high and falls out of range.
  assign off      = {8'h00, port_id} - {8'h00, BASE};
  assign in_range = off < 16'(NCH*NB);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic       sel;
    logic [7:0] bsel;
    assign sel     = in_range && off >= 16'(c*NB) && off < 16'((c+1)*NB);
    assign bsel    = off[7:0] - 8'(c*NB);
    assign vext[c] = (NB*8)'(val[c]);
    m_port_bank_ch #(
      .WIDTH(WIDTH), .NB(NB), .PULSE(PULSE_MASK[c]),
      .PULSE_LEN(PULSE_LEN), .RESET_VAL(RESET_VAL)
    ) u_ch (
      .clk(clk), .rst_n(rst_n),
      .wr_i(write_strobe && sel), .bsel_i(bsel), .data_i(out_port),
      .val_o(val[c]), .upd_o(upd[c])
    );
  end

  always_comb begin
    in_port_d = '0;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < NB; k++)
        if (off == 16'(c*NB + k)) in_port_d = vext[c][k*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_port_q <= '0;
      hit_q     <= 1'b0;
    end else begin
      in_port_q <= in_port_d;
      hit_q     <= in_range;
    end
  end

  assign in_port = in_port_q;
  assign hit     = hit_q;
  assign out     = val;
endmodule

// File: tb/tb_m_port_bank.sv
// Two banks on one shared port bus (16-bit and 12-bit channels) checked every cycle
// against a per-cycle reference model of committed values and pulse expiry times.

module tb_m_port_bank;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pid = '0, dat = '0;
  logic        ws = 1'b0;
  logic [7:0]  in0, in1;
  logic        hit0, hit1;
  logic [63:0] out0;
  logic [35:0] out1;
  logic [3:0]  upd0;
  logic [2:0]  upd1;

  always #5 clk = ~clk;

  m_port_bank #(.NCH(4), .WIDTH(16), .BASE(8'h10), .PULSE_MASK(4'b0001),
                .PULSE_LEN(5), .RESET_VAL(16'h00A5)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .port_id(pid), .out_port(dat), .write_strobe(ws),
    .in_port(in0), .hit(hit0), .out(out0), .upd(upd0));

  m_port_bank #(.NCH(3), .WIDTH(12), .BASE(8'h40), .PULSE_MASK(3'b100),
                .PULSE_LEN(3), .RESET_VAL(12'h05A)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .port_id(pid), .out_port(dat), .write_strobe(ws),
    .in_port(in1), .hit(hit1), .out(out1), .upd(upd1));

  int P_NCH[2]  = '{4, 3};
  int P_W[2]    = '{16, 12};
  int P_NB[2]   = '{2, 2};
  int P_BASE[2] = '{16, 64};
  int P_PM[2]   = '{1, 4};
  int P_PL[2]   = '{5, 3};
  int P_RV[2]   = '{165, 90};

  logic [31:0] mval[2][4];
  logic [7:0]  msh[2][4][2];
  int          mexp[2][4];
  bit          mpul[2][4];
  logic [7:0]  e_in[2];
  bit          e_hit[2];
  logic [3:0]  e_upd[2];
  int          ecnt = 0;
  int          n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse channels read 0 once the edge count reaches commit edge + PULSE_LEN.
  function automatic logic [31:0] vis(int d, int c, int n);
    if (((P_PM[d] >> c) & 1) == 1 && mpul[d][c] && n >= mexp[d][c]) return 32'd0;
    return mval[d][c];
  endfunction

  function automatic logic [31:0] dut_out(int d, int c);
    if (d == 0) return 32'(out0[c*16 +: 16]);
    return 32'(out1[c*12 +: 12]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        mval[d][c] = 32'(P_RV[d]);
        mpul[d][c] = 1'b0;
        mexp[d][c] = 0;
        msh[d][c][0] = '0;
        msh[d][c][1] = '0;
      end
      e_in[d] = '0; e_hit[d] = 1'b0; e_upd[d] = '0;
    end
  endtask

  task automatic step();
    int off[2];
    for (int d = 0; d < 2; d++) begin
      off[d]   = int'(pid) - P_BASE[d];
      e_hit[d] = off[d] >= 0 && off[d] < P_NCH[d] * P_NB[d];
      e_upd[d] = '0;
      e_in[d]  = '0;
      if (e_hit[d])
        e_in[d] = 8'(vis(d, off[d] / P_NB[d], ecnt) >> (8 * (off[d] % P_NB[d])));
    end
    ecnt++;
    for (int d = 0; d < 2; d++) begin
      if (ws && e_hit[d]) begin
        int c, b;
        logic [31:0] v;
        c = off[d] / P_NB[d];
        b = off[d] % P_NB[d];
        if (b < P_NB[d] - 1) msh[d][c][b] = dat;
        else begin
          v = 32'(dat) << (8 * (P_NB[d] - 1));
          for (int k = 0; k < P_NB[d] - 1; k++) v |= 32'(msh[d][c][k]) << (8 * k);
          mval[d][c] = v & ((32'd1 << P_W[d]) - 32'd1);
          mpul[d][c] = 1'b1;
          mexp[d][c] = ecnt + P_PL[d];
          e_upd[d][c] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < P_NCH[d]; c++)
        chk($sformatf("out%0d_ch%0d", d, c), dut_out(d, c), vis(d, c, ecnt));
    chk("upd0", 32'(upd0), 32'(e_upd[0]));
    chk("upd1", 32'(upd1), 32'(e_upd[1] & 4'b0111));
    chk("in0", 32'(in0), 32'(e_in[0]));
    chk("in1", 32'(in1), 32'(e_in[1]));
    chk("hit0", 32'(hit0), 32'(e_hit[0]));
    chk("hit1", 32'(hit1), 32'(e_hit[1]));
  endtask

  // Entered and left on a falling edge.
  task automatic cyc(input logic [7:0] p, input logic [7:0] v, input logic w);
    pid = p; dat = v; ws = w;
    @(posedge clk);
    step();
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    ws = 1'b0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    cyc(8'h12, 8'h34, 1'b1);          // shadow only: ch1 keeps reset value
    cyc(8'h13, 8'h12, 1'b1);          // commit ch1 = 0x1234
    cyc(8'h13, 8'h00, 1'b0);          // read 0x12
    cyc(8'h20, 8'h00, 1'b0);          // out of range
    cyc(8'h12, 8'h99, 1'b1);
    cyc(8'h12, 8'h00, 1'b0);          // still committed 0x34
    cyc(8'h10, 8'hCD, 1'b1);
    cyc(8'h11, 8'hAB, 1'b1);          // pulse ch0 = 0xABCD
    cyc(8'h10, 8'h01, 1'b1);
    cyc(8'h11, 8'h00, 1'b1);          // retrigger with 0x0001
    repeat (7) cyc(8'h10, 8'h00, 1'b0);
    cyc(8'h11, 8'h22, 1'b1);          // commit, then hit expiry edge with recommit
    repeat (4) cyc(8'h11, 8'h00, 1'b0);
    cyc(8'h11, 8'h33, 1'b1);
    repeat (6) cyc(8'h11, 8'h00, 1'b0);
    cyc(8'h40, 8'h21, 1'b1);
    cyc(8'h41, 8'hFF, 1'b1);          // 12-bit ch0 = 0xF21
    cyc(8'h41, 8'h00, 1'b0);          // hi byte reads 0x0F
    cyc(8'h45, 8'h07, 1'b1);          // 12-bit pulse channel
    repeat (4) cyc(8'h44, 8'h00, 1'b0);
    cyc(8'h11, 8'h55, 1'b1);          // mid-op reset: active pulse + pending shadow
    cyc(8'h14, 8'h66, 1'b1);
    do_reset();
    cyc(8'h15, 8'h77, 1'b1);          // commits with cleared shadow: 0x7700
    cyc(8'h15, 8'h00, 1'b0);
    for (int i = 0; i < 500; i++) begin
      logic [7:0] p;
      case ($urandom_range(0, 3))
        0: p = 8'($urandom_range(0, 255));
        1, 2: p = 8'($urandom_range(8'h0E, 8'h19));
        default: p = 8'($urandom_range(8'h3E, 8'h47));
      endcase
      cyc(p, 8'($urandom), $urandom_range(0, 2) != 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
